// File: rtl/seq_add_sub_n.sv
// seq_add_sub_n: multi-cycle ripple adder/subtractor.
// Each RUN cycle adds one CHUNK-bit slice and passes the carry to the next
// slice through a register. Y/CO/OV/ZERO update only when an operation
// completes, and DONE pulses for one cycle at that point.
module seq_add_sub_n #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV,
  output logic             ZERO
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  // A zero chunk, a chunk wider than the word, or a width that does not
  // divide evenly into chunks cannot be built, so stop at elaboration.
  generate
    if ((CHUNK < 1) ? 1'b1 : ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0))) begin : g_bad_params
      $error("seq_add_sub_n: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              co_q, co_d;
  logic              ov_q, ov_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_ch, b_ch;
  logic [CHUNK:0]    sum_ch;
  logic              cin_msb;
  logic [WIDTH-1:0]  acc_nxt;

  // Slice adder for the current chunk.
  // The carry into the chunk's top bit is recovered as sum ^ a ^ b at that
  // bit, which also holds when CHUNK is 1.
  always_comb begin
    a_ch    = opa_q[idx_q*CHUNK +: CHUNK];
    b_ch    = opb_q[idx_q*CHUNK +: CHUNK];
    sum_ch  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    cin_msb = sum_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    acc_nxt = acc_q;
    acc_nxt[idx_q*CHUNK +: CHUNK] = sum_ch[CHUNK-1:0];
  end

  // Next-state logic: accept in IDLE, ripple one chunk per cycle in RUN.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    y_d     = y_q;
    co_d    = co_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          opa_d   = A;
          opb_d   = B ^ {WIDTH{SnA}};
          carry_d = SnA;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_nxt;
        carry_d = sum_ch[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          y_d     = acc_nxt;
          co_d    = sum_ch[CHUNK];
          ov_d    = cin_msb ^ sum_ch[CHUNK];
          zero_d  = (acc_nxt == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so an abandoned
  // operation leaves no trace on the outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Y    = y_q;
  assign CO   = co_q;
  assign OV   = ov_q;
  assign ZERO = zero_q;

endmodule

// File: tb/tb_seq_add_sub_n.sv
// Testbench for seq_add_sub_n: three instances (CHUNK = 8, 64, 1) with
// WIDTH = 64, checked against an arithmetic reference model.
module tb_seq_add_sub_n;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SnA;
  logic [63:0] A, B;
  logic [2:0]  start;
  wire  [2:0]  busy, done, co, ov, zero;
  wire  [63:0] y0, y1, y2;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_y [3];

  always #5 CLK = ~CLK;

  seq_add_sub_n #(.WIDTH(64), .CHUNK(8)) u_c8 (
    .CLK(CLK), .RST(RST), .START(start[0]), .SnA(SnA), .A(A), .B(B),
    .BUSY(busy[0]), .DONE(done[0]), .Y(y0), .CO(co[0]), .OV(ov[0]), .ZERO(zero[0]));

  seq_add_sub_n #(.WIDTH(64), .CHUNK(64)) u_c64 (
    .CLK(CLK), .RST(RST), .START(start[1]), .SnA(SnA), .A(A), .B(B),
    .BUSY(busy[1]), .DONE(done[1]), .Y(y1), .CO(co[1]), .OV(ov[1]), .ZERO(zero[1]));

  seq_add_sub_n #(.WIDTH(64), .CHUNK(1)) u_c1 (
    .CLK(CLK), .RST(RST), .START(start[2]), .SnA(SnA), .A(A), .B(B),
    .BUSY(busy[2]), .DONE(done[2]), .Y(y2), .CO(co[2]), .OV(ov[2]), .ZERO(zero[2]));

  function automatic logic [63:0] y_of(input int sel);
    return (sel == 0) ? y0 : ((sel == 1) ? y1 : y2);
  endfunction

  // Reference: plain modular add/sub; borrow and signed overflow are
  // derived from operand magnitudes and signs.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                output logic [63:0] ry, output logic rco, output logic rov);
    logic [64:0] full;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      ry   = full[63:0];
      rco  = full[64];
      rov  = (a[63] == b[63]) && (ry[63] != a[63]);
    end else begin
      ry   = a - b;
      rco  = (a >= b);
      rov  = (a[63] != b[63]) && (ry[63] != a[63]);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic gen(output logic [63:0] a, output logic [63:0] b, output logic s);
    a = rnd_op();
    b = rnd_op();
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) b = s ? a : (~a + 64'd1);
  endtask

  // Called #1 after a rising edge. Starts one operation on instance sel,
  // scrambles the inputs after the accept edge, and checks latency,
  // result hold, results and the one-cycle DONE pulse.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input string tag);
    logic [63:0] ey;
    logic        eco, eov;
    int          lat;
    lat = (sel == 0) ? 8 : ((sel == 1) ? 1 : 64);
    model(a, b, s, ey, eco, eov);
    A = a; B = b; SnA = s; start[sel] = 1'b1;
    @(posedge CLK); #1;
    start[sel] = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; SnA = ~s;
    chk({tag, "_busy"}, 64'(busy[sel]), 64'd1);
    chk({tag, "_hold0"}, y_of(sel), last_y[sel]);
    for (int c = 1; c <= lat; c++) begin
      @(posedge CLK); #1;
      if (c == lat - 1) begin
        chk({tag, "_hold"}, y_of(sel), last_y[sel]);
        chk({tag, "_early_done"}, 64'(done[sel]), 64'd0);
      end
    end
    chk({tag, "_done"}, 64'(done[sel]), 64'd1);
    chk({tag, "_y"},    y_of(sel), ey);
    chk({tag, "_co"},   64'(co[sel]), 64'(eco));
    chk({tag, "_ov"},   64'(ov[sel]), 64'(eov));
    chk({tag, "_zero"}, 64'(zero[sel]), 64'(ey == 64'h0));
    last_y[sel] = ey;
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, 64'(done[sel]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rs;
    int          nd;

    RST = 1'b1; start = 3'b000; A = '0; B = '0; SnA = 1'b0;
    for (int i = 0; i < 3; i++) last_y[i] = 64'h0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_y",    y_of(i), 64'd0);
      chk("rst_flags", 64'({co[i], ov[i], zero[i]}), 64'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed corner cases on the CHUNK=8 instance
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "t1_wrap");
    run_op(0, 64'd5, 64'd7, 1'b1, "t2_borrow");
    run_op(0, 64'd7, 64'd5, 1'b1, "t2_noborrow");
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "t3_ovadd");
    run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, "t3_ovsub");

    // START while busy is ignored; START in the DONE cycle is accepted
    A = 64'h10; B = 64'h20; SnA = 1'b0; start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c >= 2 && c <= 5) begin
        start[0] = 1'b1;
        A = (c == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        B = (c == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        SnA = 1'($urandom_range(0, 1));
      end else begin
        start[0] = 1'b0;
      end
      @(posedge CLK); #1;
      if (done[0]) nd++;
    end
    chk("t4_ndone", 64'(nd), 64'd1);
    chk("t4_done", 64'(done[0]), 64'd1);
    chk("t4_y", y0, 64'h30);
    A = 64'd1; B = 64'd1; SnA = 1'b0; start[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK); #1;
      if (c == 1) start[0] = 1'b0;
      if (c == 4 || c == 8) begin
        chk("t4_hold", y0, 64'h30);
        chk("t4_nodone", 64'(done[0]), 64'd0);
      end
    end
    chk("t4_done2", 64'(done[0]), 64'd1);
    chk("t4_y2", y0, 64'd2);
    last_y[0] = 64'd2;
    @(posedge CLK); #1;
    chk("t4_pulse", 64'(done[0]), 64'd0);

    // Asynchronous reset in the middle of an operation
    A = 64'h1234; B = 64'h1111; SnA = 1'b0; start[0] = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge CLK);
    #4;
    RST = 1'b1;
    #1;
    chk("t5_busy", 64'(busy[0]), 64'd0);
    chk("t5_done", 64'(done[0]), 64'd0);
    chk("t5_y", y0, 64'd0);
    chk("t5_flags", 64'({co[0], ov[0], zero[0]}), 64'd0);
    #2;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) last_y[i] = 64'h0;
    @(posedge CLK); #1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (done[0] || busy[0]) nd++;
    end
    chk("t5_no_done", 64'(nd), 64'd0);
    chk("t5_y_after", y0, 64'd0);
    run_op(0, 64'h1234, 64'h1111, 1'b0, "t5_fresh");

    // Randomised vectors on each chunk size
    for (int i = 0; i < 1000; i++) begin
      gen(ra, rb, rs);
      run_op(1, ra, rb, rs, "r64");
    end
    for (int i = 0; i < 200; i++) begin
      gen(ra, rb, rs);
      run_op(0, ra, rb, rs, "r8");
    end
    for (int i = 0; i < 400; i++) begin
      gen(ra, rb, rs);
      run_op(2, ra, rb, rs, "r1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_add_sub_n.md
Name: seq_add_sub_n

Overview:
- Parametrised, multi-cycle ripple adder/subtractor with a start/done handshake. It generalises the 32-bit combinational RC add/sub to any width, default 64.
- It processes CHUNK bits per clock and carries the ripple between cycles in a register. This trades latency for a short critical path.
- It sits beside the ALU and serves wide (64-bit) add/sub. It also reports carry, signed overflow and zero flags.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per clock; 1 <= CHUNK <= WIDTH.
NCHUNK, WIDTH/CHUNK, derived local constant; number of compute cycles.

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  request; sampled on the rising edge while BUSY=0.
SnA  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with START.
A  input  WIDTH  operand A; sampled with START.
B  input  WIDTH  operand B; sampled with START.
BUSY  output  1  high while an operation is in progress.
DONE  output  1  one-cycle pulse: result and flags are valid/updated.
Y  output  WIDTH  result; held until the next completion.
CO  output  1  carry out of bit WIDTH-1. For subtract, CO=1 means no borrow (A >= B unsigned).
OV  output  1  signed overflow = carry into MSB XOR carry out of MSB.
ZERO  output  1  Y == 0.

Behaviour:
- Reset: RST=1 forces immediately, without waiting for a clock edge:
  - state=IDLE;
  - BUSY, DONE, Y, CO, OV, ZERO all 0;
  - internal operand, partial-sum, carry and index registers all 0.
- Reset mid-operation abandons the operation: no DONE is produced and outputs read 0.
- States: IDLE, RUN.
- IDLE:
  - On an edge with START=1, latch A into opA and (B XOR {WIDTH{SnA}}) into opB.
  - carry <= SnA, idx <= 0, BUSY <= 1, state <= RUN.
  - Operand changes after the accept edge have no effect.
- RUN, one edge per chunk i = idx:
  - {c, s} = opA[i*CHUNK +: CHUNK] + opB[i*CHUNK +: CHUNK] + carry.
  - Write s into acc[i*CHUNK +: CHUNK]; carry <= c; idx <= idx+1.
  - On chunk NCHUNK-1 also record cin_msb, the carry into bit WIDTH-1, from the ripple inside that chunk.
- Completion (the edge that computes chunk NCHUNK-1):
  - Y <= full result; CO <= final carry; OV <= cin_msb XOR final carry; ZERO <= (result == 0).
  - DONE <= 1, BUSY <= 0, state <= IDLE.
- DONE stays high exactly one cycle. It is cleared on the next edge unless that edge completes another operation.
- Latency:
  - START accepted at edge k → DONE high in the cycle after edge k+NCHUNK.
  - Y/CO/OV/ZERO change only at that edge.
  - CHUNK=WIDTH gives latency 1.
- START while BUSY=1 is ignored: no queueing, no effect on the running operation.
- START in the DONE cycle: state is IDLE, so it is accepted. This gives back-to-back throughput of one result per NCHUNK+1 cycles. The previous Y is held until the new completion.
- Y, CO, OV, ZERO do not glitch during RUN; they show the previous result.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement (invert B, carry-in 1), matching the RC add/sub convention.
- Illegal parameters (WIDTH % CHUNK != 0, or CHUNK=0) must be rejected at elaboration (generate-time error).

Test Plan (WIDTH=64, CHUNK=8, NCHUNK=8):
1. A=0xFFFFFFFFFFFFFFFF, B=1, SnA=0, START pulse at edge k → BUSY high from k, DONE pulse after edge k+8; Y=0, CO=1, OV=0, ZERO=1.
2. A=5, B=7, SnA=1 → Y=0xFFFFFFFFFFFFFFFE, CO=0, OV=0, ZERO=0. Also A=7, B=5, SnA=1 → Y=2, CO=1.
3. A=0x7FFFFFFFFFFFFFFF, B=1, SnA=0 → Y=0x8000000000000000, CO=0, OV=1. Then A=0x8000000000000000, B=1, SnA=1 → Y=0x7FFFFFFFFFFFFFFF, CO=1, OV=1.
4. Start A=0x10, B=0x20 add; at edges k+2..k+5 drive START=1 with A=B=0xFF.. and change A/B every cycle → exactly one DONE, Y=0x30. Next, START in the DONE cycle with A=1, B=1 → second DONE 9 cycles after the first, Y=2, Y holds 0x30 in between.
5. Start an operation, assert RST asynchronously between edges k+3 and k+4 → BUSY, DONE, Y, flags 0 immediately; no DONE after release. A fresh START then completes normally with latency 8.
6. Re-elaborate with CHUNK=64 and CHUNK=1 → random add/sub vectors (≥1000) match the A±B model mod 2^64 with correct CO/OV/ZERO. Latency is 1 and 64 cycles respectively.
